// File: rtl/truth_table_sweeper.sv
// Sequences a 4-input function block through all 16 input vectors, captures its
// truth table and scores it against an expected mask.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'hDCDC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        f_in,
    output logic [3:0]  abcd_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] captured,
    output logic        mismatch,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail_idx
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned FC_W  = 5;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(15);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  settle_cnt;
    logic              bit_fail_c;
    logic [FC_W-1:0]   fail_next_c;

    // Score of the vector being sampled this cycle; the updated count feeds mismatch.
    assign bit_fail_c  = (f_in != EXPECTED[idx]);
    assign fail_next_c = fail_count + FC_W'(bit_fail_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            abcd_out       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            captured       <= '0;
            mismatch       <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
        end else if (abort && state != IDLE) begin
            // Partial captured/fail_count are left visible until the next start.
            state    <= IDLE;
            abcd_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    abcd_out <= '0;
                    if (start && !abort) begin
                        idx            <= '0;
                        settle_cnt     <= '0;
                        captured       <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        mismatch       <= 1'b0;
                        busy           <= 1'b1;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_cnt == SETTLE_END) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    captured[idx] <= f_in;
                    fail_count    <= fail_next_c;
                    if (bit_fail_c && fail_count == '0) begin
                        first_fail_idx <= idx;
                    end
                    if (idx == LAST_IDX) begin
                        abcd_out <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mismatch <= (fail_next_c != '0);
                        state    <= DONE;
                    end else begin
                        idx        <= idx + IDX_W'(1);
                        abcd_out   <= idx + IDX_W'(1);
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
